ssu_mc: RTL and testbench

Multi-channel store-set update unit: a parametrised successor to the fixed six-source SSU. It accepts any number of dependence-pair (CAM) and no-dependence (commit) update channels, each with its own valid/ready input FIFO. A round-robin funnel serialises the entries, merges or allocates store-set IDs, and drives memory-dependence-predictor info updates to the ROB over a valid/ready handshake. It sits between the ldu/stamofu queues and the ROB.

---
 rtl/ssu_mc.sv | 238 +++++++++++++++++++++++
 tb/tb_ssu_mc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssu_mc.sv
// ssu_mc: multi-channel store-set update unit.
// Collects dependence-pair (CAM) and commit (no-dep) updates into per-channel
// FIFOs, round-robins them into one work slot, merges or allocates store-set
// IDs and emits mdp_info update beats to the ROB over valid/ready.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   dep_*      [NUM_DEP_CH]       dependence-pair input channels (valid/ready)
//   commit_*   [NUM_COMMIT_CH]    commit input channels (valid/ready)
//   rob_mdp_update_*              registered update beat to the ROB

// Per-channel FIFO. ready comes from the registered count only, so a full
// FIFO never accepts a write even if it is being popped the same cycle.
module ssu_mc_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic          ready,
  output logic          nonempty,
  output logic [DW-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          wr;

  assign ready    = (cnt != CW'(DEPTH));
  assign nonempty = (cnt != '0);
  assign wr       = push & ready;
  assign rdata    = mem[rptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr)  wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + AW'(1);
      if (pop) rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) mem[wptr] <= wdata;
  end
endmodule

module ssu_mc #(
  parameter int STORE_SET_COUNT = 64,
  parameter int SSID_WIDTH      = $clog2(STORE_SET_COUNT),
  parameter int CONF_WIDTH      = 2,
  parameter int MDPT_INFO_WIDTH = SSID_WIDTH + CONF_WIDTH,
  parameter int ROB_IDX_WIDTH   = 7,
  parameter int NUM_DEP_CH      = 4,
  parameter int NUM_COMMIT_CH   = 2,
  parameter int BUF_ENTRIES     = 4
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic [NUM_DEP_CH-1:0]                        dep_valid,
  output logic [NUM_DEP_CH-1:0]                        dep_ready,
  input  logic [NUM_DEP_CH-1:0][MDPT_INFO_WIDTH-1:0]   dep_ld_mdp_info,
  input  logic [NUM_DEP_CH-1:0][MDPT_INFO_WIDTH-1:0]   dep_stamo_mdp_info,
  input  logic [NUM_DEP_CH-1:0][ROB_IDX_WIDTH-1:0]     dep_ld_ROB_index,
  input  logic [NUM_DEP_CH-1:0][ROB_IDX_WIDTH-1:0]     dep_stamo_ROB_index,
  input  logic [NUM_COMMIT_CH-1:0]                     commit_valid,
  output logic [NUM_COMMIT_CH-1:0]                     commit_ready,
  input  logic [NUM_COMMIT_CH-1:0][MDPT_INFO_WIDTH-1:0] commit_mdp_info,
  input  logic [NUM_COMMIT_CH-1:0][ROB_IDX_WIDTH-1:0]  commit_ROB_index,
  output logic                                         rob_mdp_update_valid,
  input  logic                                         rob_mdp_update_ready,
  output logic [MDPT_INFO_WIDTH-1:0]                   rob_mdp_update_mdp_info,
  output logic [ROB_IDX_WIDTH-1:0]                     rob_mdp_update_ROB_index
);
  localparam int NCH  = NUM_DEP_CH + NUM_COMMIT_CH;
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef struct packed {
    logic [MDPT_INFO_WIDTH-1:0] ld_info;
    logic [MDPT_INFO_WIDTH-1:0] st_info;
    logic [ROB_IDX_WIDTH-1:0]   ld_idx;
    logic [ROB_IDX_WIDTH-1:0]   st_idx;
  } dep_ent_t;

  typedef struct packed {
    logic [MDPT_INFO_WIDTH-1:0] info;
    logic [ROB_IDX_WIDTH-1:0]   idx;
  } com_ent_t;

  typedef enum logic [1:0] {IDLE, EMIT_LD, EMIT_ST, EMIT_C} state_t;

  state_t                   state;
  logic [CH_W-1:0]          rr;
  logic [SSID_WIDTH-1:0]    next_ssid;
  logic [SSID_WIDTH-1:0]    wk_ssid;
  logic [ROB_IDX_WIDTH-1:0] wk_st_idx;

  logic [NCH-1:0] nonempty, pop;
  dep_ent_t       dep_head [NUM_DEP_CH];
  com_ent_t       com_head [NUM_COMMIT_CH];

  // ---- channel FIFOs ----
  for (genvar c = 0; c < NUM_DEP_CH; c++) begin : g_dep
    ssu_mc_fifo #(.DW($bits(dep_ent_t)), .DEPTH(BUF_ENTRIES)) u_fifo (
      .CLK(CLK), .RST(RST),
      .push(dep_valid[c]),
      .wdata({dep_ld_mdp_info[c], dep_stamo_mdp_info[c],
              dep_ld_ROB_index[c], dep_stamo_ROB_index[c]}),
      .pop(pop[c]), .ready(dep_ready[c]), .nonempty(nonempty[c]),
      .rdata(dep_head[c])
    );
  end

  for (genvar c = 0; c < NUM_COMMIT_CH; c++) begin : g_com
    ssu_mc_fifo #(.DW($bits(com_ent_t)), .DEPTH(BUF_ENTRIES)) u_fifo (
      .CLK(CLK), .RST(RST),
      .push(commit_valid[c]),
      .wdata({commit_mdp_info[c], commit_ROB_index[c]}),
      .pop(pop[NUM_DEP_CH+c]), .ready(commit_ready[c]),
      .nonempty(nonempty[NUM_DEP_CH+c]), .rdata(com_head[c])
    );
  end

  // ---- round-robin arbiter ----
  // Rotate the request vector so bit 0 is channel rr, take the lowest set
  // bit, then map the offset back to a global channel index.
  logic [NCH-1:0]  rot;
  logic [CH_W-1:0] off, gnt_idx, rr_nxt;
  logic [CH_W:0]   sum_raw;
  logic            gnt_any, accept, can_grant, grant;

  always_comb begin
    rot     = NCH'({nonempty, nonempty} >> rr);
    gnt_any = |rot;
    off     = '0;
    for (int i = NCH-1; i >= 0; i--)
      if (rot[i]) off = CH_W'(i);
    sum_raw = (CH_W+1)'(rr) + (CH_W+1)'(off);
    gnt_idx = CH_W'((sum_raw >= (CH_W+1)'(NCH)) ? sum_raw - (CH_W+1)'(NCH) : sum_raw);
    rr_nxt  = (gnt_idx == CH_W'(NCH-1)) ? '0 : gnt_idx + CH_W'(1);
  end

  // A new entry may only enter the work slot while idle or when the last
  // beat of the current entry leaves this cycle.
  assign accept    = rob_mdp_update_valid & rob_mdp_update_ready;
  assign can_grant = (state == IDLE) | (accept & ((state == EMIT_ST) | (state == EMIT_C)));
  assign grant     = can_grant & gnt_any;

  always_comb begin
    pop = '0;
    for (int c = 0; c < NCH; c++)
      if (grant && gnt_idx == CH_W'(c)) pop[c] = 1'b1;
  end

  // ---- head select and merge ----
  dep_ent_t dsel;
  com_ent_t csel;
  logic     is_dep;

  always_comb begin
    dsel = '0;
    csel = '0;
    for (int c = 0; c < NUM_DEP_CH; c++)
      if (gnt_idx == CH_W'(c)) dsel = dep_head[c];
    for (int c = 0; c < NUM_COMMIT_CH; c++)
      if (gnt_idx == CH_W'(NUM_DEP_CH + c)) csel = com_head[c];
  end

  assign is_dep = (gnt_idx < CH_W'(NUM_DEP_CH));

  logic [SSID_WIDTH-1:0] ld_ssid, st_ssid, c_ssid, mrg_ssid;
  logic [CONF_WIDTH-1:0] ld_conf, st_conf, c_conf, c_conf_dec;
  logic                  alloc;

  assign {ld_ssid, ld_conf} = dsel.ld_info;
  assign {st_ssid, st_conf} = dsel.st_info;
  assign {c_ssid, c_conf}   = csel.info;
  assign c_conf_dec = (c_conf == '0) ? '0 : c_conf - CONF_WIDTH'(1);

  // Store-AMO set wins, then the load's, else a fresh ID.
  always_comb begin
    alloc = 1'b0;
    if (st_conf != '0)      mrg_ssid = st_ssid;
    else if (ld_conf != '0) mrg_ssid = ld_ssid;
    else begin
      mrg_ssid = next_ssid;
      alloc    = 1'b1;
    end
  end

  // ---- emit FSM with registered outputs ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state                    <= IDLE;
      rr                       <= '0;
      next_ssid                <= '0;
      wk_ssid                  <= '0;
      wk_st_idx                <= '0;
      rob_mdp_update_valid     <= 1'b0;
      rob_mdp_update_mdp_info  <= '0;
      rob_mdp_update_ROB_index <= '0;
    end else if (grant) begin
      rr                   <= rr_nxt;
      rob_mdp_update_valid <= 1'b1;
      if (is_dep) begin
        state                    <= EMIT_LD;
        rob_mdp_update_mdp_info  <= {mrg_ssid, {CONF_WIDTH{1'b1}}};
        rob_mdp_update_ROB_index <= dsel.ld_idx;
        wk_ssid                  <= mrg_ssid;
        wk_st_idx                <= dsel.st_idx;
        if (alloc)
          next_ssid <= (next_ssid == SSID_WIDTH'(STORE_SET_COUNT-1)) ? '0
                                                                   : next_ssid + SSID_WIDTH'(1);
      end else begin
        state                    <= EMIT_C;
        rob_mdp_update_mdp_info  <= {c_ssid, c_conf_dec};
        rob_mdp_update_ROB_index <= csel.idx;
      end
    end else if (accept) begin
      if (state == EMIT_LD) begin
        state                    <= EMIT_ST;
        rob_mdp_update_mdp_info  <= {wk_ssid, {CONF_WIDTH{1'b1}}};
        rob_mdp_update_ROB_index <= wk_st_idx;
      end else begin
        state                <= IDLE;
        rob_mdp_update_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ssu_mc.sv
// Testbench for ssu_mc: random and directed traffic on all channels, a
// transaction-level model (per-channel queues, round-robin pick, store-set
// rules) predicting every beat, and a monitor that checks each beat.
module tb_ssu_mc;
  localparam int NDEP = 4, NCOM = 2, NCH = 6, IW = 8, RW = 7;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [NDEP-1:0]         dep_valid, dep_ready;
  logic [NDEP-1:0][IW-1:0] dep_ld_mdp_info, dep_stamo_mdp_info;
  logic [NDEP-1:0][RW-1:0] dep_ld_ROB_index, dep_stamo_ROB_index;
  logic [NCOM-1:0]         commit_valid, commit_ready;
  logic [NCOM-1:0][IW-1:0] commit_mdp_info;
  logic [NCOM-1:0][RW-1:0] commit_ROB_index;
  logic                    rob_v, rob_r;
  logic [IW-1:0]           rob_info;
  logic [RW-1:0]           rob_idx;

  always #5 CLK = ~CLK;

  ssu_mc dut (
    .CLK(CLK), .RST(RST),
    .dep_valid(dep_valid), .dep_ready(dep_ready),
    .dep_ld_mdp_info(dep_ld_mdp_info), .dep_stamo_mdp_info(dep_stamo_mdp_info),
    .dep_ld_ROB_index(dep_ld_ROB_index), .dep_stamo_ROB_index(dep_stamo_ROB_index),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_mdp_info(commit_mdp_info), .commit_ROB_index(commit_ROB_index),
    .rob_mdp_update_valid(rob_v), .rob_mdp_update_ready(rob_r),
    .rob_mdp_update_mdp_info(rob_info), .rob_mdp_update_ROB_index(rob_idx)
  );

  typedef struct {
    int            acc;     // clock edge at which the FIFO write happened
    bit            is_dep;
    logic [IW-1:0] a_info, b_info;
    logic [RW-1:0] a_idx, b_idx;
  } ent_t;

  typedef struct {
    logic [IW-1:0] info;
    logic [RW-1:0] idx;
  } beat_t;

  ent_t  mq [NCH][$];   // accepted entries per global channel, oldest first
  beat_t pend[$];       // predicted beats of the entry being emitted
  beat_t cur;
  bit    have_cur = 0;
  int    edge_cnt = 0;
  int    n_chk = 0, n_fail = 0, n_beats = 0;
  int    m_rr = 0, m_ssid = 0;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [IW-1:0] r8();
    return IW'($urandom);
  endfunction

  function automatic logic [RW-1:0] r7();
    return RW'($urandom);
  endfunction

  // Reference behaviour of one granted entry, written from the store-set rules.
  function automatic void expand(input ent_t e);
    int s, lc, sc, cc;
    beat_t b;
    if (e.is_dep) begin
      lc = int'(e.a_info[1:0]);
      sc = int'(e.b_info[1:0]);
      if (sc != 0)      s = int'(e.b_info[7:2]);
      else if (lc != 0) s = int'(e.a_info[7:2]);
      else begin
        s = m_ssid;
        m_ssid = (m_ssid + 1) % 64;
      end
      b.info = IW'(s * 4 + 3);
      b.idx  = e.a_idx;
      pend.push_back(b);
      b.idx  = e.b_idx;
      pend.push_back(b);
    end else begin
      cc = int'(e.a_info[1:0]);
      if (cc > 0) cc = cc - 1;
      b.info = IW'(int'(e.a_info[7:2]) * 4 + cc);
      b.idx  = e.a_idx;
      pend.push_back(b);
    end
  endfunction

  // ---- monitor ----
  initial begin
    int pick, c;
    forever begin
      @(negedge CLK);
      #1;
      if (RST) begin
        for (int i = 0; i < NCH; i++) mq[i].delete();
        pend.delete();
        have_cur = 0;
        m_rr     = 0;
        m_ssid   = 0;
      end else begin
        // entries written before the current edge were visible to the arbiter
        pick = -1;
        for (int i = 0; i < NCH; i++) begin
          c = (m_rr + i) % NCH;
          if (pick < 0 && mq[c].size() > 0 && mq[c][0].acc < edge_cnt) pick = c;
        end
        if (rob_v) begin
          if (!have_cur && pend.size() == 0) begin
            n_chk++;
            if (pick < 0) begin
              n_fail++;
              $display("FAIL grant_source: beat info %0h idx %0d shown, expected no beat", rob_info, rob_idx);
            end else begin
              expand(mq[pick].pop_front());
              m_rr = (pick + 1) % NCH;
            end
          end
          if (!have_cur && pend.size() > 0) begin
            cur = pend.pop_front();
            have_cur = 1;
          end
          if (have_cur) begin
            chk("beat_info", 32'(rob_info), 32'(cur.info));
            chk("beat_idx", 32'(rob_idx), 32'(cur.idx));
          end
          if (rob_r) begin
            have_cur = 0;
            n_beats++;
          end
        end else begin
          n_chk++;
          if (have_cur || pend.size() > 0 || pick >= 0) begin
            n_fail++;
            $display("FAIL valid_low: valid 0, expected 1 (pending beats %0d, eligible ch %0d)",
                     pend.size() + int'(have_cur), pick);
          end
        end
      end
    end
  end

  // ---- driver helpers (called at a negedge) ----
  task automatic set_dep(input int c, input logic [IW-1:0] li, input logic [IW-1:0] si,
                         input logic [RW-1:0] lx, input logic [RW-1:0] sx);
    dep_valid[c]           = 1'b1;
    dep_ld_mdp_info[c]     = li;
    dep_stamo_mdp_info[c]  = si;
    dep_ld_ROB_index[c]    = lx;
    dep_stamo_ROB_index[c] = sx;
  endtask

  task automatic set_com(input int c, input logic [IW-1:0] i, input logic [RW-1:0] x);
    commit_valid[c]     = 1'b1;
    commit_mdp_info[c]  = i;
    commit_ROB_index[c] = x;
  endtask

  // Record what the FIFOs accept at the coming edge, then advance one cycle.
  task automatic tick();
    ent_t e;
    for (int c = 0; c < NDEP; c++)
      if (dep_valid[c] && dep_ready[c]) begin
        e.acc = edge_cnt + 1; e.is_dep = 1;
        e.a_info = dep_ld_mdp_info[c];  e.b_info = dep_stamo_mdp_info[c];
        e.a_idx  = dep_ld_ROB_index[c]; e.b_idx  = dep_stamo_ROB_index[c];
        mq[c].push_back(e);
      end
    for (int c = 0; c < NCOM; c++)
      if (commit_valid[c] && commit_ready[c]) begin
        e.acc = edge_cnt + 1; e.is_dep = 0;
        e.a_info = commit_mdp_info[c]; e.b_info = '0;
        e.a_idx  = commit_ROB_index[c]; e.b_idx = '0;
        mq[NDEP+c].push_back(e);
      end
    @(negedge CLK);
    dep_valid    = '0;
    commit_valid = '0;
  endtask

  function automatic bit model_idle();
    for (int c = 0; c < NCH; c++) if (mq[c].size() > 0) return 0;
    return (pend.size() == 0) && !have_cur && !rob_v;
  endfunction

  task automatic drain();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (model_idle()) break;
      @(negedge CLK);
    end
    n_chk++;
    if (k == 3000) begin
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", k);
    end
  endtask

  task automatic do_reset(input int cycles);
    RST          = 1'b1;
    dep_valid    = '0;
    commit_valid = '0;
    repeat (cycles) @(negedge CLK);
    chk("rst_valid", 32'(rob_v), 32'd0);
    chk("rst_dep_ready", 32'(dep_ready), 32'hf);
    chk("rst_commit_ready", 32'(commit_ready), 32'h3);
    chk("rst_info", 32'(rob_info), 32'd0);
    chk("rst_idx", 32'(rob_idx), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- stimulus ----
  initial begin
    int base;
    dep_valid = '0; dep_ld_mdp_info = '0; dep_stamo_mdp_info = '0;
    dep_ld_ROB_index = '0; dep_stamo_ROB_index = '0;
    commit_valid = '0; commit_mdp_info = '0; commit_ROB_index = '0;
    rob_r = 1'b1;
    @(negedge CLK);
    do_reset(3);

    // both weak -> fresh IDs 0 then 1
    set_dep(0, {6'd5, 2'd0}, {6'd9, 2'd0}, 7'd10, 7'd20); tick(); drain();
    set_dep(0, {6'd5, 2'd0}, {6'd9, 2'd0}, 7'd10, 7'd20); tick(); drain();
    // strong stamo wins, no allocation; next weak entry gets ID 2
    set_dep(0, {6'd7, 2'd3}, {6'd12, 2'd1}, 7'd3, 7'd4); tick(); drain();
    set_dep(2, {6'd1, 2'd0}, {6'd2, 2'd0}, 7'd30, 7'd31); tick(); drain();
    // strong load only
    set_dep(3, {6'd40, 2'd2}, {6'd50, 2'd0}, 7'd8, 7'd9); tick(); drain();
    // commit confidence decrement and saturation
    set_com(0, {6'd12, 2'd2}, 7'd6); tick(); drain();
    set_com(1, {6'd12, 2'd0}, 7'd6); tick(); drain();

    // round robin: every channel gets 4 entries
    base = n_beats;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < NDEP; c++) set_dep(c, r8(), r8(), r7(), r7());
      for (int c = 0; c < NCOM; c++) set_com(c, r8(), r7());
      tick();
    end
    drain();
    chk("rr_beats", 32'(n_beats - base), 32'd40);

    // backpressure: a commit beat stalls the output, dep1 fills and drops
    base = n_beats;
    rob_r = 1'b0;
    set_com(0, r8(), r7()); tick();
    for (int k = 0; k < 6; k++) begin
      chk("bp_dep1_ready", 32'(dep_ready[1]), 32'(k < 4));
      set_dep(1, r8(), r8(), r7(), r7());
      tick();
    end
    repeat (13) @(negedge CLK);
    chk("bp_stall_beats", 32'(n_beats - base), 32'd0);
    rob_r = 1'b1;
    drain();
    chk("bp_beats", 32'(n_beats - base), 32'd9);

    // SSID allocation wraps past STORE_SET_COUNT-1
    for (int k = 0; k < 70; k++) begin
      set_dep(k % NDEP, {6'(k), 2'd0}, {6'(k + 1), 2'd0}, r7(), r7());
      tick();
      @(negedge CLK);
    end
    drain();

    // random traffic with random backpressure and a mid-stream reset
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < NDEP; c++)
        if ($urandom_range(99) < 35) set_dep(c, r8(), r8(), r7(), r7());
      for (int c = 0; c < NCOM; c++)
        if ($urandom_range(99) < 35) set_com(c, r8(), r7());
      rob_r = ($urandom_range(9) < 7);
      if (k == 200) begin
        do_reset(2);
        rob_r = 1'b1;
        set_dep(0, {6'd33, 2'd0}, {6'd44, 2'd0}, 7'd1, 7'd2);
      end
      tick();
    end
    rob_r = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
